pipe_reg_de: RTL

Parametrised decode-to-execute pipeline register with a valid/ready handshake, flush-to-bubble support and an optional skid slot. It sits between the decode stage (register-file read, immediate extend) and the execute stage. It captures the instruction, both operands, the three register addresses, the extended immediate and PC+4 as one payload. Stalls back-pressure through ready instead of gating the clock, so the same block can be instanced at every stage boundary.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_skid_slot.sv | 24 ++
 rtl/pipe_reg_de.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-to-execute pipeline register.
// The payload struct uses the default datapath widths (32-bit data, 5-bit register addresses).
package pipe_pkg;

  localparam int DE_DATA_W     = 32;
  localparam int DE_REG_ADDR_W = 5;

  // sll $0,$0,0
  localparam logic [DE_DATA_W-1:0] NOP_IR   = '0;
  localparam logic [DE_DATA_W-1:0] PC_RESET = 32'h0000_3000;

  typedef struct packed {
    logic [DE_DATA_W-1:0]     ir;
    logic [DE_DATA_W-1:0]     v1;
    logic [DE_DATA_W-1:0]     v2;
    logic [DE_REG_ADDR_W-1:0] a1;
    logic [DE_REG_ADDR_W-1:0] a2;
    logic [DE_REG_ADDR_W-1:0] a3;
    logic [DE_DATA_W-1:0]     e32;
    logic [DE_DATA_W-1:0]     pc4;
  } de_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } de_state_t;

  // Bubble: nop instruction, every other field zero, PC+4 parked at the reset PC
  function automatic de_payload_t BUBBLE(input logic [DE_DATA_W-1:0] pc_reset);
    de_payload_t b;
    b     = '0;
    b.ir  = NOP_IR;
    b.pc4 = pc_reset;
    return b;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic payload holding register with synchronous active-low reset, clear and load.
// Clear has priority over load; both reset and clear return the slot to CLR_VAL.
module pipe_skid_slot #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Slot register: reset/clear to the bubble value, otherwise load on request
  always_ff @(posedge Clock) begin
    if (!Reset || clear) begin
      q <= CLR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with valid/ready handshake and flush-to-bubble.
// Optional skid slot enabled by defining PIPE_REG_DE_SKID_EN: Ready_D then comes
// straight from the state register and capacity becomes two payloads.
//
// state    | meaning
// ST_EMPTY | main slot holds a bubble, Valid_E = 0
// ST_FULL  | main slot valid, skid slot empty
// ST_SKID  | main and skid slots valid, Ready_D = 0 (skid build only)
module pipe_reg_de #(
  parameter int                DATA_W     = pipe_pkg::DE_DATA_W,
  parameter int                REG_ADDR_W = pipe_pkg::DE_REG_ADDR_W,
  parameter logic [DATA_W-1:0] PC_RESET   = pipe_pkg::PC_RESET
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  Valid_D,
  output logic                  Ready_D,
  input  logic [DATA_W-1:0]     IR_D,
  input  logic [DATA_W-1:0]     RF_RD1,
  input  logic [DATA_W-1:0]     RF_RD2,
  input  logic [DATA_W-1:0]     EXT,
  input  logic [DATA_W-1:0]     PC4_D,
  input  logic [REG_ADDR_W-1:0] Rs_IR_D,
  input  logic [REG_ADDR_W-1:0] Rt_IR_D,
  input  logic [REG_ADDR_W-1:0] Rd_IR_D,
  output logic                  Valid_E,
  input  logic                  Ready_E,
  output logic [DATA_W-1:0]     IR_E,
  output logic [DATA_W-1:0]     V1_E,
  output logic [DATA_W-1:0]     V2_E,
  output logic [DATA_W-1:0]     E32_E,
  output logic [DATA_W-1:0]     PC4_E,
  output logic [REG_ADDR_W-1:0] A1_E,
  output logic [REG_ADDR_W-1:0] A2_E,
  output logic [REG_ADDR_W-1:0] A3_E
);
  import pipe_pkg::*;

  localparam de_payload_t BUBBLE_P = BUBBLE(PC_RESET);

  de_state_t   state_q, state_d;
  de_payload_t in_pay, main_d, main_q;
  logic        main_ld, main_clr;
  logic        accept, consume;
`ifdef PIPE_REG_DE_SKID_EN
  de_payload_t skid_q;
  logic        skid_ld, skid_clr;
`endif

  // Gather the decode-side fields into one payload
  always_comb begin
    in_pay     = '0;
    in_pay.ir  = IR_D;
    in_pay.v1  = RF_RD1;
    in_pay.v2  = RF_RD2;
    in_pay.a1  = Rs_IR_D;
    in_pay.a2  = Rt_IR_D;
    in_pay.a3  = Rd_IR_D;
    in_pay.e32 = EXT;
    in_pay.pc4 = PC4_D;
  end

  assign Valid_E = (state_q != ST_EMPTY);
`ifdef PIPE_REG_DE_SKID_EN
  assign Ready_D = Reset && (state_q != ST_SKID);
`else
  assign Ready_D = Reset && (!Valid_E || Ready_E);
`endif
  assign accept  = Valid_D && Ready_D;
  assign consume = Valid_E && Ready_E;

  // State register; reset lands in EMPTY
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slot control; Flush squashes both slots and any incoming payload
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    main_d   = in_pay;
`ifdef PIPE_REG_DE_SKID_EN
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
`endif
    if (Flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
`ifdef PIPE_REG_DE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
`ifdef PIPE_REG_DE_SKID_EN
          if (accept && !consume) begin
            skid_ld = 1'b1;
            state_d = ST_SKID;
          end else
`endif
          if (accept) begin
            main_ld = 1'b1;
          end else if (consume) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
`ifdef PIPE_REG_DE_SKID_EN
        ST_SKID: begin
          if (consume) begin
            main_d   = skid_q;
            main_ld  = 1'b1;
            skid_clr = 1'b1;
            state_d  = ST_FULL;
          end
        end
`endif
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_slot #(
    .W       ($bits(de_payload_t)),
    .CLR_VAL (BUBBLE_P)
  ) u_main (
    .Clock (Clock),
    .Reset (Reset),
    .clear (main_clr),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef PIPE_REG_DE_SKID_EN
  pipe_skid_slot #(
    .W       ($bits(de_payload_t)),
    .CLR_VAL (BUBBLE_P)
  ) u_skid (
    .Clock (Clock),
    .Reset (Reset),
    .clear (skid_clr),
    .load  (skid_ld),
    .d     (in_pay),
    .q     (skid_q)
  );
`endif

  assign IR_E  = main_q.ir;
  assign V1_E  = main_q.v1;
  assign V2_E  = main_q.v2;
  assign A1_E  = main_q.a1;
  assign A2_E  = main_q.a2;
  assign A3_E  = main_q.a3;
  assign E32_E = main_q.e32;
  assign PC4_E = main_q.pc4;

endmodule
